// File: rtl/qspi_pkg.sv
// Shared definitions for the byte-oriented SPI/Quad-SPI master engine:
// state encoding, lane/byte constants and the per-byte SCLK period helper.
package qspi_pkg;

    localparam int QUAD_LANES   = 4;
    localparam int SINGLE_LANES = 1;
    localparam int BYTE_BITS    = 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = IDLE,
        ST_SHIFT = SHIFT
    } state_e;

    // Index of the last SCLK period of a byte: 1 in quad mode, 7 in single mode.
    function automatic logic [2:0] last_period(input logic quad);
        return quad ? 3'(BYTE_BITS / QUAD_LANES - 1) : 3'(BYTE_BITS / SINGLE_LANES - 1);
    endfunction

endpackage

// File: rtl/qspi_if.sv
// Byte-streaming handshake between the register front-end (master) and the
// QSPI engine (slave).
interface qspi_if;
    import qspi_pkg::*;

    logic                 i_start;
    logic                 i_rw;
    logic                 i_q_mode;
    logic [BYTE_BITS-1:0] i_data;
    logic [BYTE_BITS-1:0] o_data;
    logic                 o_dval;
    logic                 o_dload;
    logic                 o_ready;

    modport master (
        output i_start, i_rw, i_q_mode, i_data,
        input  o_data, o_dval, o_dload, o_ready
    );

    modport slave (
        input  i_start, i_rw, i_q_mode, i_data,
        output o_data, o_dval, o_dload, o_ready
    );

endinterface

// File: rtl/qspi_shift_reg.sv
// 8-bit shifter shared by transmit and receive: parallel load, then shifts
// left by one lane (single) or four lanes (quad), MSB/high nibble leaving first.
module qspi_shift_reg
    import qspi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BYTE_BITS-1:0]  load_data,
    input  logic                  shift_en,
    input  logic                  quad,
    input  logic [QUAD_LANES-1:0] shift_in,
    output logic [BYTE_BITS-1:0]  data
);

    logic [BYTE_BITS-1:0] data_q, data_d;

    always_comb begin
        // NOTE: default to the held value first so no path through this block infers a latch.
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift_en) begin
            if (quad) begin
                data_d = {data_q[BYTE_BITS-QUAD_LANES-1:0], shift_in};
            end else begin
                data_d = {data_q[BYTE_BITS-SINGLE_LANES-1:0], shift_in[SINGLE_LANES-1:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
        if (rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/qspi_module.sv
// SPI/Quad-SPI master engine: mode-0 SCLK at clk/2, active-low chip select,
// byte streaming through the start/load/valid handshake on a 4-bit SIO bus.
module qspi_module
    import qspi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    qspi_if.slave      bus,
    output logic       o_sclk,
    output logic       o_cs,
    inout  wire  [3:0] SIO
);

    logic [0:0]           state_q, state_d;
    logic                 sclk_q, sclk_d;
    logic                 cs_q, cs_d;
    logic                 ready_q, ready_d;
    logic                 dval_q, dval_d;
    logic                 dload_q, dload_d;
    logic                 rw_q, rw_d;
    logic                 quad_q, quad_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [BYTE_BITS-1:0] rx_q, rx_d;

    logic                  sr_load;
    logic                  sr_shift;
    logic [BYTE_BITS-1:0]  sr_data;
    logic [QUAD_LANES-1:0] sr_in;
    logic [QUAD_LANES-1:0] sio_out;
    logic [QUAD_LANES-1:0] sio_oe;

    // Single-lane reads take MISO from SIO[1]; quad reads take all four lanes.
    assign sr_in = quad_q ? SIO : {3'b000, SIO[1]};

    qspi_shift_reg u_shift_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sr_load),
        .load_data (bus.i_data),
        .shift_en  (sr_shift),
        .quad      (quad_q),
        .shift_in  (sr_in),
        .data      (sr_data)
    );

    always_comb begin
        state_d  = state_q;
        sclk_d   = sclk_q;
        cs_d     = cs_q;
        ready_d  = ready_q;
        rw_d     = rw_q;
        quad_d   = quad_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        dval_d   = 1'b0;
        dload_d  = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = SHIFT;
                    rw_d    = bus.i_rw;
                    quad_d  = bus.i_q_mode;
                    cs_d    = 1'b0;
                    ready_d = 1'b0;
                    sclk_d  = 1'b0;
                    cnt_d   = '0;
                    sr_load = 1'b1;
                    dload_d = 1'b1;
                end
            end

            SHIFT: begin
                if (!sclk_q) begin
                    // Rising SCLK edge: reads sample SIO here.
                    sclk_d   = 1'b1;
                    sr_shift = rw_q;
                end else begin
                    sclk_d = 1'b0;
                    if (cnt_q == last_period(quad_q)) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            rx_d   = sr_data;
                            dval_d = 1'b1;
                        end
                        if (bus.i_start) begin
                            sr_load = 1'b1;
                            dload_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            cs_d    = 1'b1;
                            ready_d = 1'b1;
                        end
                    end else begin
                        // Falling SCLK edge inside a byte: writes advance to the next lane group.
                        cnt_d    = cnt_q + 3'd1;
                        sr_shift = !rw_q;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            ready_q <= 1'b1;
            dval_q  <= 1'b0;
            dload_q <= 1'b0;
            rw_q    <= 1'b0;
            quad_q  <= 1'b0;
            cnt_q   <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            ready_q <= ready_d;
            dval_q  <= dval_d;
            dload_q <= dload_d;
            rw_q    <= rw_d;
            quad_q  <= quad_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
        end
    end

    always_comb begin
        sio_oe  = '0;
        sio_out = '0;
        if (state_q == SHIFT && !rw_q) begin
            if (quad_q) begin
                sio_oe  = 4'b1111;
                sio_out = sr_data[BYTE_BITS-1 -: QUAD_LANES];
            end else begin
                sio_oe  = 4'b0001;
                sio_out = {3'b000, sr_data[BYTE_BITS-1]};
            end
        end
    end

    for (genvar i = 0; i < QUAD_LANES; i++) begin : g_sio
        assign SIO[i] = sio_oe[i] ? sio_out[i] : 1'bz;
    end

    assign o_sclk      = sclk_q;
    assign o_cs        = cs_q;
    assign bus.o_ready = ready_q;
    assign bus.o_dval  = dval_q;
    assign bus.o_dload = dload_q;
    assign bus.o_data  = rx_q;

endmodule

// File: tb/tb_qspi_module.sv
// Scoreboard bench for qspi_module: stimulus plans each transaction into
// expected-symbol, read-byte and chip-select queues; monitors pop and compare.
`timescale 1ns/1ps
module tb_qspi_module;
    import qspi_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       o_sclk;
    logic       o_cs;
    wire  [3:0] sio;
    logic [3:0] tb_sio;
    logic       tb_rd_en;

    qspi_if bus ();

    // Undriven SIO lanes read back as 1, so a released lane is observable.
    for (genvar i = 0; i < 4; i++) begin : g_pu
        pullup (sio[i]);
    end
    assign sio = (tb_rd_en && !o_cs) ? tb_sio : 4'bzzzz;

    qspi_module dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .o_sclk (o_sclk),
        .o_cs   (o_cs),
        .SIO    (sio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic       quad;
        logic [3:0] val;
    } sym_t;

    sym_t       sym_q[$];
    logic [7:0] dval_q[$];
    int         cs_len_q[$];
    logic [3:0] drv_q[$];
    logic [7:0] tx_bytes[$];

    int n_checks = 0;
    int n_fail   = 0;
    int dload_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event with no expectation queued at %0t", name, $time);
    endtask

    // Monitor: idle/busy invariants, SIO content at each SCLK rise, read bytes, CS-low length.
    initial begin
        logic prev_sclk;
        int   cs_run;
        sym_t s;
        prev_sclk = 1'b0;
        cs_run    = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                prev_sclk = 1'b0;
                cs_run    = 0;
            end else begin
                if (o_cs) begin
                    check("idle_ready", 32'(bus.o_ready), 32'd1);
                    check("idle_sclk", 32'(o_sclk), 32'd0);
                    check("idle_sio_released", 32'(sio), 32'hF);
                    if (cs_run != 0) begin
                        if (cs_len_q.size() == 0) flag_fail("cs_low_run");
                        else check("cs_low_len", cs_run, cs_len_q.pop_front());
                        cs_run = 0;
                    end
                end else begin
                    check("busy_ready", 32'(bus.o_ready), 32'd0);
                    cs_run++;
                end
                if (o_sclk && !prev_sclk) begin
                    if (sym_q.size() == 0) begin
                        flag_fail("sclk_rise");
                    end else begin
                        s = sym_q.pop_front();
                        if (s.wr && s.quad) check("quad_wr_sio", 32'(sio), 32'(s.val));
                        if (s.wr && !s.quad) check("single_wr_sio", 32'(sio), 32'({3'b111, s.val[0]}));
                    end
                end
                prev_sclk = o_sclk;
                if (bus.o_dval) begin
                    if (dval_q.size() == 0) flag_fail("o_dval");
                    else check("rd_data", 32'(bus.o_data), 32'(dval_q.pop_front()));
                end
                if (bus.o_dload) dload_seen++;
            end
        end
    end

    // Flash model for reads: presents the next planned lane value during each SCLK low phase.
    initial begin
        tb_sio = 4'h0;
        forever begin
            @(negedge clk);
            if (!rst_n && tb_rd_en && !o_cs && !o_sclk)
                tb_sio = (drv_q.size() != 0) ? drv_q.pop_front() : 4'($urandom);
        end
    end

    task automatic plan_txn(input bit rd, input bit quad);
        logic [7:0] b;
        for (int k = 0; k < tx_bytes.size(); k++) begin
            b = tx_bytes[k];
            if (quad) begin
                sym_q.push_back('{wr: !rd, quad: 1'b1, val: b[7:4]});
                sym_q.push_back('{wr: !rd, quad: 1'b1, val: b[3:0]});
                drv_q.push_back(b[7:4]);
                drv_q.push_back(b[3:0]);
            end else begin
                for (int j = 7; j >= 0; j--) begin
                    sym_q.push_back('{wr: !rd, quad: 1'b0, val: {3'b000, b[j]}});
                    drv_q.push_back({2'($urandom), b[j], 1'($urandom)});
                end
            end
            if (rd) dval_q.push_back(b);
        end
        if (!rd) drv_q.delete();
        cs_len_q.push_back(tx_bytes.size() * (quad ? 4 : 16));
    endtask

    task automatic run_txn(input bit rd, input bit quad, input bit toggle_modes);
        int n;
        int t;
        int base;
        n    = tx_bytes.size();
        base = dload_seen;
        plan_txn(rd, quad);
        tb_rd_en = rd;
        @(negedge clk);
        bus.i_rw     = rd;
        bus.i_q_mode = quad;
        bus.i_data   = tx_bytes[0];
        bus.i_start  = 1'b1;
        for (int k = 0; k < n; k++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.o_dload && t < 40);
            check("dload_pulse", 32'(bus.o_dload), 32'd1);
            check("dload_latency", t, (k == 0) ? 1 : (quad ? 4 : 16));
            if (k + 1 < n) begin
                bus.i_data = tx_bytes[k+1];
            end else begin
                bus.i_start = 1'b0;
                bus.i_data  = 8'($urandom);
            end
            if (toggle_modes) begin
                bus.i_rw     = 1'($urandom);
                bus.i_q_mode = 1'($urandom);
            end
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.o_ready && t < 64);
        check("end_ready", 32'(bus.o_ready), 32'd1);
        @(negedge clk);
        tb_rd_en = 1'b0;
        check("dload_count", dload_seen - base, n);
        check("sclk_symbols_left", sym_q.size(), 0);
        check("rd_bytes_left", dval_q.size(), 0);
        check("cs_runs_left", cs_len_q.size(), 0);
        drv_q.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int t;
        rst_n        = 1'b1;
        tb_rd_en     = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_rw     = 1'b0;
        bus.i_q_mode = 1'b0;
        bus.i_data   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(o_cs), 32'd1);
        check("rst_sclk", 32'(o_sclk), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_dval", 32'(bus.o_dval), 32'd0);
        check("rst_dload", 32'(bus.o_dload), 32'd0);
        check("rst_data", 32'(bus.o_data), 32'd0);
        check("rst_sio", 32'(sio), 32'hF);
        rst_n = 1'b0;

        // i_start held low: engine stays idle with no handshake activity.
        t = dload_seen;
        repeat (20) @(negedge clk);
        check("idle_no_dload", dload_seen - t, 0);
        check("idle_data", 32'(bus.o_data), 32'd0);

        tx_bytes = '{8'hAA, 8'h5A, 8'h5A};
        run_txn(1'b0, 1'b1, 1'b0);
        tx_bytes = '{8'h55, 8'hAA};
        run_txn(1'b1, 1'b1, 1'b0);
        tx_bytes = '{8'hAA, 8'h55};
        run_txn(1'b0, 1'b0, 1'b0);
        tx_bytes = '{8'hFF, 8'hFF};
        run_txn(1'b1, 1'b0, 1'b1);
        tx_bytes = '{8'h3C, 8'hC3};
        run_txn(1'b0, 1'b1, 1'b1);

        for (int r = 0; r < 12; r++) begin
            tx_bytes.delete();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
            run_txn(1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of a quad write.
        tx_bytes = '{8'hC3, 8'h3C};
        plan_txn(1'b0, 1'b1);
        @(negedge clk);
        bus.i_rw     = 1'b0;
        bus.i_q_mode = 1'b1;
        bus.i_data   = 8'hC3;
        bus.i_start  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.o_dload && t < 40);
        check("pre_reset_dload", 32'(bus.o_dload), 32'd1);
        bus.i_data = 8'h3C;
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        bus.i_start = 1'b0;
        @(negedge clk);
        check("midrst_cs", 32'(o_cs), 32'd1);
        check("midrst_sclk", 32'(o_sclk), 32'd0);
        check("midrst_ready", 32'(bus.o_ready), 32'd1);
        check("midrst_sio", 32'(sio), 32'hF);
        check("midrst_dval", 32'(bus.o_dval), 32'd0);
        check("midrst_dload", 32'(bus.o_dload), 32'd0);
        check("midrst_data", 32'(bus.o_data), 32'd0);
        sym_q.delete();
        dval_q.delete();
        cs_len_q.delete();
        drv_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);

        tx_bytes = '{8'h96};
        run_txn(1'b1, 1'b1, 1'b0);
        tx_bytes = '{8'h69};
        run_txn(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
